// File: rtl/comp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | comp_pkg                                                              |
// | Shared types and flag positions for the comparator self-test engine.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bist_state_t;

    localparam int FLAG_EQ = 2;
    localparam int FLAG_GT = 1;
    localparam int FLAG_LT = 0;

    typedef logic [2:0] flags_t;

endpackage
`default_nettype wire

// File: rtl/comp_golden.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | comp_golden                                                           |
// | Combinational expected {eq,gt,lt} for an upper-vs-lower operand bus.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module comp_golden
    import comp_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic [2*WIDTH-1:0] data,
    output flags_t             expected
);

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;

    assign w_a = data[2*WIDTH-1:WIDTH];
    assign w_b = data[WIDTH-1:0];

    always_comb begin
        expected          = '0;
        expected[FLAG_EQ] = (w_a == w_b);
        expected[FLAG_GT] = (w_a >  w_b);
        expected[FLAG_LT] = (w_a <  w_b);
    end

endmodule
`default_nettype wire

// File: rtl/comp_bist.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | comp_bist                                                             |
// | Exhaustive sweep of comparator operand pairs with scoring and capture.|
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module comp_bist
    import comp_pkg::*;
#(
    parameter int WIDTH = 2,
    parameter int ERRW  = 2*WIDTH+1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic [2*WIDTH-1:0]  data,
    input  logic                eq,
    input  logic                gt,
    input  logic                lt,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRW-1:0]     err_count,
    output logic [2*WIDTH-1:0]  first_fail,
    output logic [2:0]          first_fail_flags,
    output logic                fail_seen
);

    localparam logic [2*WIDTH-1:0] c_last     = '1;
    localparam logic [2*WIDTH-1:0] c_data_one = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0]    c_err_max  = '1;
    localparam logic [ERRW-1:0]    c_err_one  = {{(ERRW-1){1'b0}}, 1'b1};

    bist_state_t          r_state;
    bist_state_t          w_state_nxt;
    logic [2*WIDTH-1:0]   r_data;
    logic [ERRW-1:0]      r_err_count;
    logic [2*WIDTH-1:0]   r_first_fail;
    flags_t               r_first_fail_flags;
    logic                 r_fail_seen;

    flags_t               w_expected;
    flags_t               w_flags;
    logic                 w_mismatch;
    logic                 w_clear;
    logic                 w_score;
    logic                 w_last;

    comp_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .data     (r_data),
        .expected (w_expected)
    );

    always_comb begin
        w_flags          = '0;
        w_flags[FLAG_EQ] = eq;
        w_flags[FLAG_GT] = gt;
        w_flags[FLAG_LT] = lt;
    end

    // Any bit difference counts, so invalid triples (000, multi-hot) always fail.
    assign w_mismatch = (w_flags != w_expected);
    assign w_last     = (r_data == c_last);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_score     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end
            end
            RUN: begin
                busy    = 1'b1;
                w_score = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_state_nxt = RUN;
                    w_clear     = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data             <= '0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_flags <= '0;
            r_fail_seen        <= 1'b0;
        end else if (w_clear) begin
            r_data             <= '0;
            r_err_count        <= '0;
            r_first_fail       <= '0;
            r_first_fail_flags <= '0;
            r_fail_seen        <= 1'b0;
        end else if (w_score) begin
            if (w_mismatch) begin
                if (r_err_count != c_err_max) begin
                    r_err_count <= r_err_count + c_err_one;
                end
                if (!r_fail_seen) begin
                    r_first_fail       <= r_data;
                    r_first_fail_flags <= w_flags;
                    r_fail_seen        <= 1'b1;
                end
            end
            // The final vector is held so DONE still shows the last operand pair.
            if (!w_last) begin
                r_data <= r_data + c_data_one;
            end
        end
    end

    assign data             = r_data;
    assign err_count        = r_err_count;
    assign first_fail       = r_first_fail;
    assign first_fail_flags = r_first_fail_flags;
    assign fail_seen        = r_fail_seen;
    assign pass             = done & ~r_fail_seen;

endmodule
`default_nettype wire

// File: tb/tb_comp_bist.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_comp_bist                                                          |
// | Randomized self-checking bench for comp_bist with a table comparator. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_comp_bist;

    localparam int WIDTH = 2;
    localparam int N     = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;

    logic [3:0]  data,  data4;
    logic        eq, gt, lt, eq4, gt4, lt4;
    logic        busy, done, pass, fail_seen;
    logic        busy4, done4, pass4, fail_seen4;
    logic [4:0]  err_count;
    logic [3:0]  err_count4;
    logic [3:0]  first_fail, first_fail4;
    logic [2:0]  first_fail_flags, first_fail_flags4;

    // Comparator under test is a lookup table the bench can corrupt per vector.
    logic [2:0]  resp [N];

    int checks = 0;
    int errors = 0;

    int sweep_busy;
    bit sweep_seq_ok;
    bit sweep_timeout;

    int         m_err;
    logic [3:0] m_ff;
    logic [2:0] m_fff;

    always #5 clk = ~clk;

    assign {eq, gt, lt}    = resp[data];
    assign {eq4, gt4, lt4} = resp[data4];

    comp_bist #(.WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .data(data),
        .eq(eq), .gt(gt), .lt(lt),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail(first_fail), .first_fail_flags(first_fail_flags),
        .fail_seen(fail_seen)
    );

    comp_bist #(.WIDTH(WIDTH), .ERRW(4)) dut4 (
        .clk(clk), .reset(reset), .start(start), .data(data4),
        .eq(eq4), .gt(gt4), .lt(lt4),
        .busy(busy4), .done(done4), .pass(pass4), .err_count(err_count4),
        .first_fail(first_fail4), .first_fail_flags(first_fail_flags4),
        .fail_seen(fail_seen4)
    );

    function automatic logic [2:0] golden(input int v);
        int a, b;
        a = v / 4;
        b = v % 4;
        return {a == b, a > b, a < b};
    endfunction

    task automatic load_clean();
        for (int v = 0; v < N; v++) resp[v] = golden(v);
    endtask

    // Reference: walk all vectors once and tally mismatches against arithmetic truth.
    task automatic model_sweep();
        bit seen;
        seen  = 0;
        m_err = 0;
        m_ff  = 4'd0;
        m_fff = 3'd0;
        for (int v = 0; v < N; v++) begin
            if (resp[v] !== golden(v)) begin
                m_err++;
                if (!seen) begin
                    seen  = 1;
                    m_ff  = 4'(v);
                    m_fff = resp[v];
                end
            end
        end
    endtask

    task automatic run_sweep(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        sweep_busy    = 0;
        sweep_seq_ok  = 1;
        sweep_timeout = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                sweep_timeout = 0;
                break;
            end
            if (busy) begin
                if (data !== 4'(sweep_busy)) sweep_seq_ok = 0;
                sweep_busy++;
            end
        end
        start = 1'b0;
        checks++;
        if (sweep_timeout) begin
            errors++;
            $display("FAIL sweep_timeout: done never rose, busy cycles %0d", sweep_busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({data, busy, done, pass, err_count, first_fail, first_fail_flags, fail_seen} !== 20'd0) begin
            errors++;
            $display("FAIL reset_values: data=%h busy=%b done=%b pass=%b err=%0d ff=%h fff=%b seen=%b, required all zero",
                     data, busy, done, pass, err_count, first_fail, first_fail_flags, fail_seen);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data !== 4'd0) begin
            errors++;
            $display("FAIL idle_hold: busy=%b done=%b data=%h, required 0 0 0", busy, done, data);
        end
    endtask

    task automatic test_clean_sweep();
        load_clean();
        run_sweep(0);
        checks++;
        if (sweep_busy !== N || !sweep_seq_ok) begin
            errors++;
            $display("FAIL clean_busy: busy cycles %0d seq_ok %b, required %0d 1", sweep_busy, sweep_seq_ok, N);
        end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1 || err_count !== 5'd0 || fail_seen !== 1'b0) begin
            errors++;
            $display("FAIL clean_result: done=%b pass=%b err=%0d seen=%b, required 1 1 0 0", done, pass, err_count, fail_seen);
        end
    endtask

    task automatic test_single_fault();
        load_clean();
        resp[10] = 3'b010;
        run_sweep(0);
        checks++;
        if (err_count !== 5'd1 || first_fail !== 4'hA || first_fail_flags !== 3'b010) begin
            errors++;
            $display("FAIL single_fault_capture: err=%0d ff=%h fff=%b, required 1 a 010", err_count, first_fail, first_fail_flags);
        end
        checks++;
        if (pass !== 1'b0 || fail_seen !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("FAIL single_fault_flags: pass=%b seen=%b done=%b, required 0 1 1", pass, fail_seen, done);
        end
    endtask

    task automatic test_stuck_zero();
        for (int v = 0; v < N; v++) resp[v] = 3'b000;
        run_sweep(0);
        checks++;
        if (err_count !== 5'd16 || first_fail !== 4'h0 || first_fail_flags !== 3'b000) begin
            errors++;
            $display("FAIL stuck_zero: err=%0d ff=%h fff=%b, required 16 0 000", err_count, first_fail, first_fail_flags);
        end
        checks++;
        if (err_count4 !== 4'd15 || pass4 !== 1'b0) begin
            errors++;
            $display("FAIL stuck_zero_saturate: err=%0d pass=%b, required 15 0", err_count4, pass4);
        end
    endtask

    task automatic test_reset_midsweep();
        bit hit;
        load_clean();
        resp[2] = 3'b111;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (data == 4'd7 && busy) begin
                hit = 1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL midsweep_reach: data=%h busy=%b, required data 7 in RUN", data, busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({data, busy, done, pass, err_count, first_fail, first_fail_flags, fail_seen} !== 20'd0) begin
            errors++;
            $display("FAIL midsweep_reset: data=%h busy=%b done=%b pass=%b err=%0d ff=%h fff=%b seen=%b, required all zero",
                     data, busy, done, pass, err_count, first_fail, first_fail_flags, fail_seen);
        end
        @(negedge clk);
        reset = 1'b0;
        load_clean();
        run_sweep(0);
        checks++;
        if (sweep_busy !== N || !sweep_seq_ok || pass !== 1'b1 || err_count !== 5'd0) begin
            errors++;
            $display("FAIL post_reset_sweep: busy %0d seq %b pass=%b err=%0d, required %0d 1 1 0",
                     sweep_busy, sweep_seq_ok, pass, err_count, N);
        end
    endtask

    task automatic test_hold_start();
        for (int v = 0; v < N; v++) resp[v] = 3'b000;
        run_sweep(1);
        checks++;
        if (sweep_busy !== N || !sweep_seq_ok || done !== 1'b1 || err_count !== 5'd16) begin
            errors++;
            $display("FAIL hold_start: busy %0d seq %b done=%b err=%0d, required %0d 1 1 16",
                     sweep_busy, sweep_seq_ok, done, err_count, N);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pass !== 1'b0) begin
            errors++;
            $display("FAIL done_stays: done=%b busy=%b pass=%b, required 1 0 0", done, busy, pass);
        end
        load_clean();
        run_sweep(0);
        checks++;
        if (pass !== 1'b1 || err_count !== 5'd0 || fail_seen !== 1'b0 || first_fail !== 4'h0 || first_fail_flags !== 3'b000) begin
            errors++;
            $display("FAIL restart_from_done: pass=%b err=%0d seen=%b ff=%h fff=%b, required 1 0 0 0 000",
                     pass, err_count, fail_seen, first_fail, first_fail_flags);
        end
    endtask

    task automatic test_random();
        int exp4;
        for (int it = 0; it < 8; it++) begin
            for (int v = 0; v < N; v++) begin
                if ($urandom_range(0, 3) == 0) resp[v] = 3'($urandom_range(0, 7));
                else                           resp[v] = golden(v);
            end
            model_sweep();
            exp4 = (m_err > 15) ? 15 : m_err;
            run_sweep(0);
            checks++;
            if (err_count !== 5'(m_err) || err_count4 !== 4'(exp4)) begin
                errors++;
                $display("FAIL rand_err[%0d]: err=%0d err4=%0d, required %0d %0d", it, err_count, err_count4, m_err, exp4);
            end
            checks++;
            if (first_fail !== m_ff || first_fail_flags !== m_fff || fail_seen !== (m_err != 0)) begin
                errors++;
                $display("FAIL rand_capture[%0d]: ff=%h fff=%b seen=%b, required %h %b %b",
                         it, first_fail, first_fail_flags, fail_seen, m_ff, m_fff, m_err != 0);
            end
            checks++;
            if (pass !== (m_err == 0) || done !== 1'b1 || sweep_busy !== N) begin
                errors++;
                $display("FAIL rand_status[%0d]: pass=%b done=%b busy %0d, required %b 1 %0d",
                         it, pass, done, sweep_busy, m_err == 0, N);
            end
        end
    endtask

    initial begin
        load_clean();
        test_reset();
        test_clean_sweep();
        test_single_fault();
        test_stuck_zero();
        test_reset_midsweep();
        test_hold_start();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
